// File: rtl/hls_saturation_requant.sv
// hls_saturation_requant: rescale three 24-bit channel products to RGB888 with clamping and per-frame clip counting
module hls_saturation_requant #(
   parameter int FRAC_BITS = 8,
   parameter int CNT_W     = 24
) (
   input  logic             ap_clk,
   input  logic             ap_rst_n,
   input  logic             rnd_en,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [71:0]      s_data,
   input  logic             s_user,
   input  logic             s_last,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [23:0]      m_data,
   output logic             m_user,
   output logic             m_last,
   output logic [CNT_W-1:0] clip_cnt,
   output logic [CNT_W-1:0] clip_cnt_frame
);
   localparam logic [24:0] rnd_add = 25'(1) << (FRAC_BITS - 1);
   logic             en;
   logic             v1_q, u1_q, l1_q;
   logic [2:0][24:0] r_q, r_d, q_d;
   logic [2:0]       clip_d;
   logic [23:0]      byte_d;
   logic [1:0]       nclip_d;
   logic [CNT_W:0]   sum_d;
   logic [CNT_W-1:0] cnt_d;
   logic             m_valid_q, m_user_q, m_last_q;
   logic [23:0]      m_data_q;
   logic [CNT_W-1:0] clip_cnt_q, clip_frame_q;
   assign en             = m_ready | ~m_valid_q;
   assign s_ready        = en;
   assign m_valid        = m_valid_q;
   assign m_data         = m_data_q;
   assign m_user         = m_user_q;
   assign m_last         = m_last_q;
   assign clip_cnt       = clip_cnt_q;
   assign clip_cnt_frame = clip_frame_q;
   // rounding offset is chosen from rnd_en of the beat being accepted
   always_comb begin
      r_d = '0;
      for (int c = 0; c < 3; c++)
         r_d[c] = {1'b0, s_data[c*24 +: 24]} + (rnd_en ? rnd_add : 25'd0);
   end
   // shift out the fraction and clamp each channel to a byte
   always_comb begin
      q_d    = '0;
      clip_d = '0;
      byte_d = '0;
      for (int c = 0; c < 3; c++) begin
         q_d[c]             = r_q[c] >> FRAC_BITS;
         clip_d[c]          = |q_d[c][24:8];
         byte_d[c*8 +: 8]   = clip_d[c] ? 8'hFF : q_d[c][7:0];
      end
   end
   // a start-of-frame beat restarts the count; otherwise accumulate and saturate
   always_comb begin
      nclip_d = 2'(clip_d[0]) + 2'(clip_d[1]) + 2'(clip_d[2]);
      sum_d   = {1'b0, clip_cnt_q} + {{(CNT_W-1){1'b0}}, nclip_d};
      cnt_d   = u1_q ? {{(CNT_W-2){1'b0}}, nclip_d} : sum_d[CNT_W] ? '1 : sum_d[CNT_W-1:0];
   end
   // stage 1: capture rounded sums and sideband of the accepted beat
   always_ff @(posedge ap_clk or negedge ap_rst_n)
      if (!ap_rst_n) begin
         v1_q <= 1'b0;
         u1_q <= 1'b0;
         l1_q <= 1'b0;
         r_q  <= '0;
      end else if (en) begin
         v1_q <= s_valid;
         u1_q <= s_user;
         l1_q <= s_last;
         r_q  <= r_d;
      end
   // stage 2: output register; counters move only when a real beat loads here
   always_ff @(posedge ap_clk or negedge ap_rst_n)
      if (!ap_rst_n) begin
         m_valid_q    <= 1'b0;
         m_data_q     <= '0;
         m_user_q     <= 1'b0;
         m_last_q     <= 1'b0;
         clip_cnt_q   <= '0;
         clip_frame_q <= '0;
      end else if (en) begin
         m_valid_q <= v1_q;
         m_data_q  <= byte_d;
         m_user_q  <= u1_q;
         m_last_q  <= l1_q;
         if (v1_q) begin
            clip_cnt_q   <= cnt_d;
            clip_frame_q <= u1_q ? clip_cnt_q : clip_frame_q;
         end
      end
endmodule

// File: doc/hls_saturation_requant.md
Name: hls_saturation_requant

Overview:
- Downstream stage of the saturation-enhance multiplier.
- Consumes three unsigned 24-bit channel products (16-bit pixel term x 8-bit gain) and rescales each by FRAC_BITS with optional round-half-up.
- Clamps each result to 8 bits and emits packed RGB888 on a valid/ready stream.
- Counts clipped channels per frame so firmware can tune the gain register.

Parameters:
- FRAC_BITS, 8, number of fractional bits removed from each product (legal range 1..16).
- CNT_W, 24, width of the clip counters.

Ports:
- ap_clk  in  1  single clock, rising edge
- ap_rst_n  in  1  asynchronous active-low reset
- rnd_en  in  1  1 = round half-up before shift, 0 = truncate; sampled per beat at input acceptance
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid & s_ready
- s_data  in  72  channel products: [71:48] ch2, [47:24] ch1, [23:0] ch0
- s_user  in  1  start-of-frame marker
- s_last  in  1  end-of-line marker
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream ready
- m_data  out  24  [23:16] ch2, [15:8] ch1, [7:0] ch0
- m_user  out  1  s_user delayed with its beat
- m_last  out  1  s_last delayed with its beat
- clip_cnt  out  CNT_W  clipped channels in the current frame so far
- clip_cnt_frame  out  CNT_W  total clipped channels of the last completed frame

Behaviour:
Pipeline
- Two register stages; latency exactly 2 cycles from acceptance to m_valid when unstalled; throughput 1 beat/cycle.
- Shared advance enable: en = m_ready | ~m_valid.
- s_ready = en (combinational from m_ready).
- When en = 0, both stages hold data, user, last and valid unchanged.
- Bubbles (stage 1 empty) are squashed: stage 2 loads when en is high even if stage 2 is full and m_ready is high.

Stage 1
- Per channel, 25-bit sum r = p + (rnd_en ? 2^(FRAC_BITS-1) : 0). No overflow: 0xFFFFFF + 0x80 fits in 25 bits.
- Stage 1 valid = s_valid & s_ready.

Stage 2
- Per channel: q = r >> FRAC_BITS.
- Output byte = 8'hFF if q > 255, else q[7:0].
- clip flag = (q > 255).

Reset
- Asynchronous; on ap_rst_n low:
  - m_valid = 0, m_data = 0, m_user = 0, m_last = 0
  - stage-1 valid = 0
  - clip_cnt = 0, clip_cnt_frame = 0
- s_ready = 1 once reset is released.
- Reset mid-frame discards in-flight beats; no partial output follows reset.

Clip counting
- Updated only when stage 2 loads a valid beat.
- nclip = popcount of the three clip flags (0..3).
- If the loaded beat has user = 1: clip_cnt_frame <= clip_cnt; clip_cnt <= nclip.
- Otherwise: clip_cnt <= clip_cnt + nclip, saturating at all-ones (never wraps).
- clip_cnt_frame holds until the next user beat reaches stage 2.
- Stalls never double-count: the count is tied to the stage-2 load, not to the output handshake.

Boundary conditions
- Simultaneous s_valid and m_ready = 0 with the pipe full: s_ready = 0, no beat is lost or duplicated.
- Back-to-back user beats each close a frame; a frame with zero clips yields clip_cnt_frame = 0.
- rnd_en changes mid-stream affect only beats accepted after the change.

Test Plan:
1. Reset, then ch0 = 0x000C80, rnd_en = 0, m_ready = 1 -> two cycles later m_data[7:0] = 0x0C. Repeat with rnd_en = 1 -> 0x0D.
2. ch0 = 0x00FFFF, ch1 = 0x010000, ch2 = 0xFFFFFF, rnd_en = 1 -> m_data = {0xFF, 0xFF, 0xFF} (ch0: 0xFFFF + 0x80 = 0x1007F, >> 8 = 256, clipped). clip_cnt increases by 3.
3. Stream 10 beats with m_ready toggling pseudo-randomly -> output sequence identical to input order; s_ready low only while m_valid & ~m_ready; user/last stay aligned.
4. Frame A: user beat, then 4 beats with 2 clips each (8 total). Frame B: user beat with 0 clips -> on B's user load, clip_cnt_frame = 8 and clip_cnt = 0.
5. Preload clip_cnt near max (CNT_W = 4, 14 clips), add a beat with 3 clips -> clip_cnt = 15 (saturated, no wrap).
6. Assert ap_rst_n low asynchronously with two beats in flight -> m_valid drops immediately. After release, the first output is the first beat accepted post-reset, and the counters read 0.
